// File: rtl/reg_file_mp_pkg.sv
// Shared widths, FSM encodings and a depth helper for the multi-port register file.
// Defaults here seed the parameters of reg_file_mp and reg_file_clear_ctrl.
package reg_file_mp_pkg;

  localparam int REG_FILE_XLEN       = 32;
  localparam int REG_FILE_ADDR_WIDTH = 5;
  localparam int RF_MAX_RD_PORTS     = 4;

  localparam logic RF_STATE_CLEAR = 1'b0;
  localparam logic RF_STATE_RUN   = 1'b1;

  typedef enum logic {
    ST_CLEAR = RF_STATE_CLEAR,
    ST_RUN   = RF_STATE_RUN
  } rf_state_e;

  function automatic int pow2(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// Post-reset clear sequencer: walks every entry once, then raises ready.
// Latency: ready rises exactly 2**ADDR_W cycles after rst deasserts.
// Backpressure: none; the top ignores writes and zeroes reads until ready.
module reg_file_clear_ctrl
  import reg_file_mp_pkg::*;
#(
  parameter int ADDR_W = REG_FILE_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam int              DEPTH = pow2(ADDR_W);
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  rf_state_e       state;
  // One extra bit so the terminal compare never sees a wrapped value.
  logic [ADDR_W:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + ONE;
          if (cnt == LAST) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign clr_we   = (state == ST_CLEAR);
  assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised writes (port 1 wins).
// Latency: reads 0 cycles, writes visible next cycle; optional forwarding via REG_FILE_BYPASS_EN.
// Backpressure: writes dropped and reads forced to 0 while ready is low after reset.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN     = REG_FILE_XLEN,
  parameter int ADDR_W   = REG_FILE_ADDR_WIDTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [XLEN-1:0]          wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [XLEN-1:0]          wd1,
  output logic                     ready
);

  localparam int   DEPTH = pow2(ADDR_W);
  localparam logic ZR    = (ZERO_REG != 0);

  if (NUM_RD < 1 || NUM_RD > RF_MAX_RD_PORTS) begin : g_bad_num_rd
    $error("reg_file_mp: NUM_RD out of range");
  end

  logic [XLEN-1:0]   mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              w0_en;
  logic              w1_en;
  logic              w0_live;

  reg_file_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // Write qualifiers already exclude entry 0 when it is hardwired, so the
  // forwarding path below inherits the same rule for free.
  assign w0_en   = ready & we0 & ~(ZR & (wa0 == '0));
  assign w1_en   = ready & we1 & ~(ZR & (wa1 == '0));
  assign w0_live = w0_en & ~(w1_en & (wa0 == wa1));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (w0_live) mem[wa0] <= wd0;
      if (w1_en)   mem[wa1] <= wd1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [XLEN-1:0]   arr_val;
    logic [XLEN-1:0]   byp_val;

    assign ra      = rd_addr[i*ADDR_W +: ADDR_W];
    assign arr_val = (ZR && (ra == '0)) ? '0 : mem[ra];

`ifdef REG_FILE_BYPASS_EN
    always_comb begin
      byp_val = arr_val;
      if (w1_en && (wa1 == ra))      byp_val = wd1;
      else if (w0_en && (wa0 == ra)) byp_val = wd0;
    end
`else
    assign byp_val = arr_val;
`endif

    assign rd_data[i*XLEN +: XLEN] = ready ? byp_val : '0;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: ZERO_REG=1 and ZERO_REG=0 instances driven in parallel,
// directed vectors plus randomized traffic against an array-based model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_z;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        ready, ready_z;

  int total = 0;
  int bad   = 0;

  logic [31:0] m1 [32];
  logic [31:0] m0 [32];
  int          since = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ready(ready)
  );

  reg_file_mp #(.XLEN(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_z),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ready(ready_z)
  );

  function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] a);
    logic [31:0] v;
    if (since != 32) return 32'h0;
    if (zr && a == 5'd0) return 32'h0;
    v = zr ? m1[a] : m0[a];
`ifdef REG_FILE_BYPASS_EN
    if (we1 && wa1 == a) v = wd1;
    else if (we0 && wa0 == a) v = wd0;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] er;
    er = (since == 32) ? 32'd1 : 32'd0;
    chk({tag, "_ready"},   {31'b0, ready},   er);
    chk({tag, "_ready_z"}, {31'b0, ready_z}, er);
    chk({tag, "_p0"},   rd_data[31:0],    exp_rd(1'b1, rd_addr[4:0]));
    chk({tag, "_p1"},   rd_data[63:32],   exp_rd(1'b1, rd_addr[9:5]));
    chk({tag, "_z_p0"}, rd_data_z[31:0],  exp_rd(1'b0, rd_addr[4:0]));
    chk({tag, "_z_p1"}, rd_data_z[63:32], exp_rd(1'b0, rd_addr[9:5]));
  endtask

  // Advance one clock, updating the model from the inputs seen at that edge.
  task automatic tick();
    if (since == 32) begin
      if (we0 && wa0 != 5'd0) m1[wa0] = wd0;
      if (we1 && wa1 != 5'd0) m1[wa1] = wd1;
      if (we0) m0[wa0] = wd0;
      if (we1) m0[wa1] = wd1;
    end
    if (rst) since = 0;
    else if (since < 32) begin
      m1[since] = 32'h0;
      m0[since] = 32'h0;
      since++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = 5'd0; wd0 = 32'h0;
    we1 = 1'b0; wa1 = 5'd0; wd1 = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      chk({tag, "_p0"},   rd_data[31:0],    32'h0);
      chk({tag, "_p1"},   rd_data[63:32],   32'h0);
      chk({tag, "_z_p0"}, rd_data_z[31:0],  32'h0);
      chk({tag, "_z_p1"}, rd_data_z[63:32], 32'h0);
    end
  endtask

  typedef struct {
    bit          we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    bit          we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] ez0;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] e;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0, 32'h0,        32'h0,        32'h12345678};
    tbl[2] = '{1'b1, 5'd7,  32'hAAAA0000, 1'b1, 5'd7,  32'h5555FFFF, 5'd7,  5'd7, 32'h5555FFFF, 32'h5555FFFF, 32'h5555FFFF};
    tbl[3] = '{1'b1, 5'd3,  32'h11113333, 1'b1, 5'd4,  32'h44440000, 5'd3,  5'd4, 32'h11113333, 32'h44440000, 32'h11113333};
    tbl[4] = '{1'b1, 5'd9,  32'h00000001, 1'b0, 5'd0,  32'h0,        5'd9,  5'd5, 32'h00000001, 32'hDEADBEEF, 32'h00000001};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd0, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D};
    tbl[6] = '{1'b0, 5'd5,  32'hFFFFFFFF, 1'b0, 5'd31, 32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF};

    idle();
    rst = 1'b1;
    rd_addr = 10'd0;
    tick();
    tick();
    rst = 1'b0;

    // Clear sequence length and reads during clear.
    chk("rst_ready", {31'b0, ready}, 32'h0);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      chk("clr_rd0", rd_data[31:0], 32'h0);
      tick();
      n++;
    end
    chk("clear_len", n, 32);
    chk("clear_ready_z", {31'b0, ready_z}, 32'h1);
    check_all_zero("post_clear");

    // Directed write/read vectors.
    foreach (tbl[k]) begin
      we0 = tbl[k].we0; wa0 = tbl[k].wa0; wd0 = tbl[k].wd0;
      we1 = tbl[k].we1; wa1 = tbl[k].wa1; wd1 = tbl[k].wd1;
      tick();
      idle();
      rd_addr = {tbl[k].ra1, tbl[k].ra0};
      #1;
      chk($sformatf("vec%0d_p0", k),   rd_data[31:0],   tbl[k].e0);
      chk($sformatf("vec%0d_p1", k),   rd_data[63:32],  tbl[k].e1);
      chk($sformatf("vec%0d_z_p0", k), rd_data_z[31:0], tbl[k].ez0);
    end

    // Same-cycle read of a location being written (x9 old=1, new=2).
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h2;
    rd_addr = {5'd9, 5'd9};
    #1;
`ifdef REG_FILE_BYPASS_EN
    e = 32'h2;
`else
    e = 32'h1;
`endif
    chk("same_cyc_p0", rd_data[31:0], e);
    chk("same_cyc_p1", rd_data[63:32], e);
    tick();
    idle();
    #1;
    chk("after_wr_x9", rd_data[31:0], 32'h2);

    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h33;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h44;
    #1;
`ifdef REG_FILE_BYPASS_EN
    e = 32'h44;
`else
    e = 32'h2;
`endif
    chk("same_cyc_both", rd_data[31:0], e);
    tick();
    idle();
    #1;
    chk("after_both_x9", rd_data[31:0], 32'h44);

    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h77;
    rd_addr = {5'd0, 5'd0};
    #1;
`ifdef REG_FILE_BYPASS_EN
    e = 32'h77;
`else
    e = 32'h12345678;
`endif
    chk("same_cyc_x0", rd_data[31:0], 32'h0);
    chk("same_cyc_x0_z", rd_data_z[31:0], e);
    tick();
    idle();

    // Fill x1..x31, then reset again in the middle of the clear sequence.
    for (int a = 1; a < 32; a++) begin
      we0 = 1'b1; wa0 = 5'(a); wd0 = 32'(a) * 32'h01010101 + 32'h100;
      tick();
    end
    idle();
    rd_addr = {5'd31, 5'd17};
    #1;
    chk("fill_x17", rd_data[31:0],  32'h11111211);
    chk("fill_x31", rd_data[63:32], 32'h1F1F201F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst1_ready", {31'b0, ready}, 32'h0);
    for (int c = 0; c < 9; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      we0 = 1'b1; wa0 = 5'($urandom_range(1, 31)); wd0 = $urandom | 32'h1;
      chk("clr2_rd1", rd_data[63:32], 32'h0);
      tick();
      n++;
    end
    idle();
    chk("clear2_len", n, 32);
    check_all_zero("post_clear2");

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst = (c < 360) && ($urandom_range(0, 149) == 0);
      we0 = 1'($urandom); wa0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      we1 = 1'($urandom); wa1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wd0 = $urandom; wd1 = $urandom;
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom)};
      #1;
      check_all("rnd");
      tick();
    end
    rst = 1'b0;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
